// File: rtl/emu_run_ctrl.sv
// emu_run_ctrl: run/step controller for an emulation target.
// Owns the PAUSED/RUNNING/STEPPING state. Produces the DUT, FF-scan and RAM-scan clock enables
// from that state and the live model stall lines. Counts executed and stalled DUT cycles.
module emu_run_ctrl #(
    parameter int unsigned NUM_STALL = 2,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_start,
    input  logic [CNT_WIDTH-1:0] run_cycles,
    input  logic                 pause_req,
    input  logic [NUM_STALL-1:0] stall,
    input  logic                 ff_scan,
    input  logic                 ram_scan,
    output logic                 dut_clk_en,
    output logic                 ff_clk_en,
    output logic                 ram_clk_en,
    output logic                 paused,
    output logic                 done,
    output logic [63:0]          cycle_count,
    output logic [63:0]          stall_count,
    output logic                 scan_err
);

    typedef enum logic [1:0] {StPaused, StRunning, StStepping} state_e;

    localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
    logic                 done_q, done_d;
    logic [63:0]          cycle_q, cycle_d;
    logic [63:0]          stall_cnt_q, stall_cnt_d;
    logic                 scan_err_q, scan_err_d;

    logic stall_any;
    logic active;
    logic dut_en;
    logic last_step;

    // State register and all registered bookkeeping, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StPaused;
            remaining_q <= '0;
            done_q      <= 1'b0;
            cycle_q     <= '0;
            stall_cnt_q <= '0;
            scan_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            cycle_q     <= cycle_d;
            stall_cnt_q <= stall_cnt_d;
            scan_err_q  <= scan_err_d;
        end
    end

    // Next-state logic: start decode in PAUSED, pause handling, step countdown.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        unique case (state_q)
            StPaused: begin
                // A coincident pause request wins and the start pulse is dropped.
                if (run_start && !pause_req) begin
                    if (run_cycles == '0) begin
                        state_d = StRunning;
                    end else begin
                        state_d     = StStepping;
                        remaining_d = run_cycles;
                    end
                end
            end
            StRunning: begin
                if (pause_req) begin
                    state_d = StPaused;
                end
            end
            StStepping: begin
                // Stalled cycles do not consume the step budget.
                if (dut_en) begin
                    remaining_d = remaining_q - CntOne;
                end
                if (last_step || pause_req) begin
                    state_d = StPaused;
                end
            end
            default: state_d = StPaused;
        endcase
    end

    // Outputs: clock enables are combinational from registered state and live stall/scan.
    always_comb begin
        stall_any  = |stall;
        active     = (state_q != StPaused);
        paused     = !active;
        dut_en     = active && !stall_any;
        last_step  = (state_q == StStepping) && dut_en && (remaining_q == CntOne);
        dut_clk_en = dut_en;
        ff_clk_en  = dut_en || (paused && ff_scan);
        ram_clk_en = dut_en || (paused && ram_scan);
        done        = done_q;
        cycle_count = cycle_q;
        stall_count = stall_cnt_q;
        scan_err    = scan_err_q;
    end

    // Counters, done pulse and sticky scan error; counters wrap silently.
    always_comb begin
        done_d      = last_step;
        cycle_d     = cycle_q + 64'(dut_en);
        stall_cnt_d = stall_cnt_q + 64'(active && stall_any);
        scan_err_d  = scan_err_q || (active && (ff_scan || ram_scan));
    end

endmodule
